// File: rtl/noise_video_gen.sv
// Noise video source: pixel-enable divider, H/V raster counters, blank/sync decode
// and a Galois-LFSR luminance that repeats each line pair in line-doubled mode.
module noise_video_gen #(
  parameter int H_ACTIVE  = 320,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 32,
  parameter int H_BP      = 32,
  parameter int V_ACTIVE  = 240,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 3,
  parameter int V_BP_NTSC = 16,
  parameter int V_BP_PAL  = 66
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pal,
  input  logic       scandouble,
  output logic       ce_pix,
  output logic       HBlank,
  output logic       HSync,
  output logic       VBlank,
  output logic       VSync,
  output logic [7:0] video
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT_NTSC = V_ACTIVE + V_FP + V_SYNC + V_BP_NTSC;
  localparam int VT_PAL  = V_ACTIVE + V_FP + V_SYNC + V_BP_PAL;
  localparam int VT_MAX  = (VT_PAL > VT_NTSC) ? VT_PAL : VT_NTSC;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(2 * VT_MAX);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VL_NTSC  = VW'(VT_NTSC - 1);
  localparam logic [VW-1:0] VL_PAL   = VW'(VT_PAL - 1);
  localparam logic [VW-1:0] VL_NTSC2 = VW'(2 * VT_NTSC - 1);
  localparam logic [VW-1:0] VL_PAL2  = VW'(2 * VT_PAL - 1);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [1:0]    div;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          pal_q;
  logic          dbl_q;
  logic [15:0]   lfsr;
  logic [15:0]   line_seed;

  logic          tick;
  logic          h_wrap;
  logic          frame_end;
  logic [VW-1:0] v_last;
  logic [VW-1:0] line;
  logic          hb_d;
  logic          hs_d;
  logic          vb_d;
  logic          vs_d;
  logic          active;
  logic          reload;
  logic [15:0]   lfsr_cur;
  logic [15:0]   lfsr_nxt;

  always_comb begin
    tick      = dbl_q ? (div == 2'd1) : (div == 2'd3);
    h_wrap    = (hcnt == H_LAST);
    if (dbl_q) v_last = pal_q ? VL_PAL2 : VL_NTSC2;
    else       v_last = pal_q ? VL_PAL  : VL_NTSC;
    frame_end = h_wrap && (vcnt == v_last);
    line      = dbl_q ? (vcnt >> 1) : vcnt;
    hb_d      = (hcnt >= H_ACT_C);
    hs_d      = (hcnt >= HS_START) && (hcnt < HS_END);
    vb_d      = (line >= V_ACT_C);
    vs_d      = (line >= VS_START) && (line < VS_END);
    active    = !hb_d && !vb_d;
    // Second copy of a doubled line restarts from the seed captured on the first copy.
    reload    = dbl_q && vcnt[0] && (hcnt == '0);
    lfsr_cur  = reload ? line_seed : lfsr;
    lfsr_nxt  = (lfsr_cur >> 1) ^ (lfsr_cur[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div       <= '0;
      hcnt      <= '0;
      vcnt      <= '0;
      pal_q     <= 1'b0;
      dbl_q     <= 1'b0;
      lfsr      <= LFSR_SEED;
      line_seed <= LFSR_SEED;
      ce_pix    <= 1'b0;
      HBlank    <= 1'b0;
      HSync     <= 1'b0;
      VBlank    <= 1'b0;
      VSync     <= 1'b0;
      video     <= 8'h00;
    end else begin
      ce_pix <= tick;
      // Wrapping on tick also clears div at a frame start where the mode changes.
      div    <= tick ? 2'd0 : div + 2'd1;
      if (tick) begin
        HBlank <= hb_d;
        HSync  <= hs_d;
        VBlank <= vb_d;
        VSync  <= vs_d;
        video  <= active ? lfsr_cur[7:0] : 8'h00;
        lfsr   <= active ? lfsr_nxt : lfsr_cur;
        if ((hcnt == '0) && !vcnt[0]) line_seed <= lfsr;
        hcnt <= h_wrap ? '0 : hcnt + HW'(1);
        if (h_wrap) vcnt <= frame_end ? '0 : vcnt + VW'(1);
        if (frame_end) begin
          pal_q <= pal;
          dbl_q <= scandouble;
        end
      end
    end
  end

endmodule

// File: tb/tb_noise_video_gen.sv
// Bench for noise_video_gen: a full-size instance for line/LFSR/reset checks and a
// shrunken-raster instance for frame length, PAL switch and line-doubled checks.
module tb_noise_video_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, pal_a, dbl_a, ce_a, hb_a, hs_a, vb_a, vs_a;
  logic [7:0] vid_a;
  logic       rst_b, pal_b, dbl_b, ce_b, hb_b, hs_b, vb_b, vs_b;
  logic [7:0] vid_b;

  noise_video_gen dut_a (
    .clk(clk), .reset_n(rst_a), .pal(pal_a), .scandouble(dbl_a),
    .ce_pix(ce_a), .HBlank(hb_a), .HSync(hs_a), .VBlank(vb_a), .VSync(vs_a), .video(vid_a)
  );

  noise_video_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP_NTSC(1), .V_BP_PAL(3)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .pal(pal_b), .scandouble(dbl_b),
    .ce_pix(ce_b), .HBlank(hb_b), .HSync(hs_b), .VBlank(vb_b), .VSync(vs_b), .video(vid_b)
  );

  logic       use_b;
  logic       o_ce, o_hb, o_hs, o_vb, o_vs;
  logic [7:0] o_vid;
  always_comb begin
    o_ce  = use_b ? ce_b  : ce_a;
    o_hb  = use_b ? hb_b  : hb_a;
    o_hs  = use_b ? hs_b  : hs_a;
    o_vb  = use_b ? vb_b  : vb_a;
    o_vs  = use_b ? vs_b  : vs_a;
    o_vid = use_b ? vid_b : vid_a;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference raster: position derived from strobe index within the frame.
  int          m_ht, m_hact, m_hs0, m_hs1, m_vact, m_vs0, m_vs1, m_vtn, m_vtp;
  int          m_n;
  bit          m_pal, m_dbl;
  logic [15:0] m_lfsr;
  logic [7:0]  rep [0:511];

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic set_model(input int ha, hf, hsw, hbp, va, vf, vsw, bpn, bpp);
    m_ht = ha + hf + hsw + hbp; m_hact = ha; m_hs0 = ha + hf; m_hs1 = ha + hf + hsw;
    m_vact = va; m_vs0 = va + vf; m_vs1 = va + vf + vsw;
    m_vtn = va + vf + vsw + bpn; m_vtp = va + vf + vsw + bpp;
  endtask

  task automatic model_reset();
    m_n = 0; m_pal = 0; m_dbl = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_next(output logic [31:0] exp_vec);
    int r, h, line, per, vt;
    bit hb, hs, vb, vs;
    logic [7:0] v;
    vt = m_pal ? m_vtp : m_vtn;
    if (m_n == m_ht * vt * (m_dbl ? 2 : 1)) begin
      m_n = 0;
      m_pal = use_b ? pal_b : pal_a;
      m_dbl = use_b ? dbl_b : dbl_a;
    end
    r = m_n / m_ht; h = m_n % m_ht;
    line = m_dbl ? r / 2 : r;
    hb = (h >= m_hact); hs = (h >= m_hs0) && (h < m_hs1);
    vb = (line >= m_vact); vs = (line >= m_vs0) && (line < m_vs1);
    v = 8'h00;
    if (!hb && !vb) begin
      if (m_dbl && (r % 2 == 1)) v = rep[h];
      else begin
        v = m_lfsr[7:0];
        rep[h] = v;
        m_lfsr = lfsr_step(m_lfsr);
      end
    end
    per = m_dbl ? 2 : 4;
    m_n++;
    exp_vec = {15'd0, per[3:0], 1'b1, hb, hs, vb, vs, v};
  endtask

  task automatic do_strobe(input string tag, output int clks);
    logic [31:0] exp_vec;
    clks = 0;
    do begin
      @(posedge clk); #1;
      clks++;
    end while (!o_ce && clks < 12);
    model_next(exp_vec);
    check(tag, {15'd0, clks[3:0], o_ce, o_hb, o_hs, o_vb, o_vs, o_vid}, exp_vec);
  endtask

  int          clks, hb_cnt, hs_cnt, hs_first;
  logic [15:0] s;
  logic [7:0]  pwr [0:19];
  int          fi, pos, fclk, fvs;
  bit          prev_vb;
  int          fl [0:3], fc [0:3], fv [0:3];
  logic [7:0]  a0 [0:15], a1 [0:15];

  initial begin
    use_b = 0;
    rst_a = 0; pal_a = 0; dbl_a = 0;
    rst_b = 0; pal_b = 0; dbl_b = 0;
    set_model(320, 16, 32, 32, 240, 3, 3, 16, 66);
    model_reset();

    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {o_ce, o_hb, o_hs, o_vb, o_vs, o_vid}, 0);

    // Power-on release: first strobe 4 clocks later, pixel 0 carries the seed low byte.
    @(negedge clk); rst_a = 1;
    do_strobe("pix_first", clks);
    check("first_video", o_vid, 8'hE1);
    check("first_blank", {o_hb, o_vb}, 0);
    pwr[0] = o_vid;
    hb_cnt = 0; hs_cnt = 0; hs_first = -1;
    for (int i = 1; i < 400; i++) begin
      do_strobe("pix_line0", clks);
      if (i < 20) pwr[i] = o_vid;
      if (o_hb) hb_cnt++;
      if (o_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
    end
    check("hblank_len", hb_cnt, 80);
    check("hsync_start", hs_first, 336);
    check("hsync_len", hs_cnt, 32);

    // Blanking freezes the LFSR: line 1 resumes with the 321st sequence value.
    s = 16'hACE1;
    for (int i = 0; i < 320; i++) s = lfsr_step(s);
    do_strobe("pix_line1", clks);
    check("line1_first_video", o_vid, s[7:0]);
    for (int i = 1; i < 500; i++) do_strobe("pix_line1", clks);

    // Asynchronous reset in the middle of an active line.
    @(negedge clk); #2 rst_a = 0;
    #1 check("async_reset_outputs", {o_ce, o_hb, o_hs, o_vb, o_vs, o_vid}, 0);
    repeat (2) @(negedge clk);
    rst_a = 1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      do_strobe("pix_after_reset", clks);
      check("restart_video", o_vid, pwr[i]);
    end
    @(negedge clk); rst_a = 0;

    // Small raster: NTSC 24x10, PAL 24x12.
    use_b = 1;
    set_model(16, 2, 4, 2, 6, 1, 2, 1, 3);
    model_reset();
    @(negedge clk); rst_b = 1;
    fi = 0; pos = 0; fclk = 0; fvs = 0; prev_vb = 0;
    for (int k = 0; k < 1105; k++) begin
      if (k == 100) pal_b = 1;
      if (k == 340) dbl_b = 1;
      do_strobe("pix_small", clks);
      if (k > 0 && prev_vb && !o_vb && !o_hb) begin
        if (fi < 4) begin
          fl[fi] = pos; fc[fi] = fclk; fv[fi] = fvs;
        end
        fi++; pos = 0; fclk = 0; fvs = 0;
      end
      if (fi == 2 && pos < 40) begin
        if (pos < 16) a0[pos] = o_vid;
        else if (pos >= 24) a1[pos - 24] = o_vid;
      end
      pos++; fclk += clks; fvs += int'(o_vs);
      prev_vb = o_vb;
    end
    check("frames_seen", fi, 3);
    check("ntsc_strobes", fl[0], 240);
    check("ntsc_clks", fc[0], 960);
    check("ntsc_vsync", fv[0], 48);
    check("pal_strobes", fl[1], 288);
    check("pal_clks", fc[1], 1152);
    check("pal_vsync", fv[1], 48);
    check("dbl_strobes", fl[2], 576);
    check("dbl_clks", fc[2], 1152);
    check("dbl_vsync", fv[2], 96);
    for (int h = 0; h < 16; h++) check("pair_video", a1[h], a0[h]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
